// File: rtl/ins_bit_dispatch_pkg.sv
// Shared field widths, fetch-entry layout and occupancy states for the
// instruction dispatch queue.
package ZionDataType;
    localparam int OP_W     = 7;
    localparam int REG_W    = 5;
    localparam int F3_W     = 3;
    localparam int F7_W     = 7;
    localparam int INS_W    = 32;
    // Entry PC is sized for the widest supported core; narrower PCs are zero-extended.
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [INS_W-1:0]    ins;
        logic [PC_MAX_W-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_e;
endpackage

// File: rtl/ins_fifo_core.sv
// Fetch-entry storage ring plus read/write pointers. Storage is never reset;
// only the pointers are.
module ins_fifo_core
    import ZionDataType::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // DEPTH is a power of two, so natural overflow wraps DEPTH-1 back to 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign rd_entry = mem_q[rd_ptr_q];
endmodule

// File: rtl/ins_bit_dispatch.sv
// Fetch-to-decode instruction queue that splits the head word into RISC-V fields.
// Optional head-opcode legality flag: define INS_ILLEGAL_CHECK_EN.
module ins_bit_dispatch
    import ZionDataType::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INS_W-1:0]  in_ins,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [REG_W-1:0]  out_rd,
    output logic [F3_W-1:0]   out_funct3,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic [F7_W-1:0]   out_funct7,
    output logic [INS_W-1:0]  out_ins,
`ifdef INS_ILLEGAL_CHECK_EN
    output logic              out_illegal,
`endif
    output logic [PC_W-1:0]   out_pc
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] count_q, count_d;
    occ_state_e       state_q;
    logic             push, pop;
    fetch_entry_t     wr_entry, rd_entry;
    logic             unused_pc;

    assign in_ready  = (state_q != OCC_FULL) && !rst;
    assign out_valid = (state_q != OCC_EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // Push+pop together never changes occupancy, so only one-sided moves step the state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY:   if (push) state_q <= OCC_PARTIAL;
                OCC_PARTIAL: begin
                    if (push && !pop && count_q == CNT_W'(DEPTH - 1))
                        state_q <= OCC_FULL;
                    else if (pop && !push && count_q == CNT_W'(1))
                        state_q <= OCC_EMPTY;
                end
                OCC_FULL:    if (pop) state_q <= OCC_PARTIAL;
                default:     state_q <= OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        wr_entry     = '0;
        wr_entry.ins = in_ins;
        wr_entry.pc  = PC_MAX_W'(in_pc);
    end

    ins_fifo_core #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry)
    );

    assign out_ins    = rd_entry.ins;
    assign out_op     = rd_entry.ins[6:0];
    assign out_rd     = rd_entry.ins[11:7];
    assign out_funct3 = rd_entry.ins[14:12];
    assign out_rs1    = rd_entry.ins[19:15];
    assign out_rs2    = rd_entry.ins[24:20];
    assign out_funct7 = rd_entry.ins[31:25];
    assign out_pc     = rd_entry.pc[PC_W-1:0];
    assign unused_pc  = ^rd_entry.pc;

`ifdef INS_ILLEGAL_CHECK_EN
    assign out_illegal = out_valid && (rd_entry.ins[1:0] != 2'b11);
`endif
endmodule
